// File: rtl/mips_pkg.sv
// Shared constants for the register-file write-back path.
//   RF_AW     : register address width
//   RF_DW     : register data width
//   REG_ZERO  : hard-wired zero register; writes to it are dropped
//   WB_*      : write-back requester indices on the arbiter
//   rr_next() : round-robin successor of an index modulo n
package mips_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int WB_ALU    = 0;
  localparam int WB_LOAD   = 1;
  localparam int WB_MULDIV = 2;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin grant logic. Searches req starting at index ptr and wrapping
// modulo N; the first asserted request wins.
//   req   : request vector
//   ptr   : highest-priority index this cycle (0..N-1)
//   en    : when low, no grant is produced
//   grant : one-hot grant (all zero when nothing granted)
//   gidx  : index of the granted requester (0 when nothing granted)
module rr_arbiter #(
  parameter int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx
);

  // Walk from the lowest priority (ptr+N-1) down to ptr so that the last
  // match found, which overwrites earlier ones, is the highest priority.
  always_comb begin
    grant = '0;
    gidx  = '0;
    if (en) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[(int'(ptr) + i) % N]) begin
          grant                        = '0;
          grant[(int'(ptr) + i) % N]   = 1'b1;
          gidx                         = PW'((int'(ptr) + i) % N);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Shares the port round-robin among NREQ sources, registers the winning
// write into a one-entry output stage, and forwards that in-flight write to
// both combinational read ports.
//   clk, rst                 : clock, async active-high reset
//   req_valid/req_ready      : per-requester handshake (ready is one-hot)
//   req_waddr/req_wdata      : packed per-requester address/data
//   wb_hold                  : blocks all grants while high
//   rf_we/rf_waddr/rf_wdata  : registered write to the register file
//   raddr1/2, rf_rdata1/2    : read addresses and raw register-file data
//   rdata1/2                 : read data with in-flight write forwarded
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_waddr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic              wb_hold,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  input  logic [DW-1:0]     rf_rdata1,
  input  logic [DW-1:0]     rf_rdata2,
  output logic [DW-1:0]     rdata1,
  output logic [DW-1:0]     rdata2
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gidx;
  logic            accept;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;

  // Reset also gates grants so no requester sees ready during reset.
  rr_arbiter #(.N(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (~wb_hold & ~rst),
    .grant (grant),
    .gidx  (gidx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_waddr[i*AW +: AW];
        sel_data = req_wdata[i*DW +: DW];
      end
    end
  end

  // r0 writes are still handshaked so the source retires, but never
  // reach the register file.
  always_comb begin
    ptr_d      = ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (accept) begin
      ptr_d      = PW'(rr_next(int'(gidx), NREQ));
      rf_we_d    = (sel_addr != AW'(REG_ZERO));
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // rf_we is already zero for r0, the explicit check keeps the mux safe
  // if the output stage ever carries an r0 address with we set.
  assign rdata1 = (rf_we_q && rf_waddr_q == raddr1 && raddr1 != AW'(REG_ZERO))
                  ? rf_wdata_q : rf_rdata1;
  assign rdata2 = (rf_we_q && rf_waddr_q == raddr2 && raddr2 != AW'(REG_ZERO))
                  ? rf_wdata_q : rf_rdata2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_waddr;
  logic [NREQ*DW-1:0] req_wdata;
  logic              wb_hold;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [AW-1:0]     raddr1, raddr2;
  logic [DW-1:0]     rf_rdata1, rf_rdata2;
  logic [DW-1:0]     rdata1, rdata2;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] regs [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .wb_hold   (wb_hold),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rdata1    (rdata1),
    .rdata2    (rdata2)
  );

  // Register file model beside the arbiter: r0 reads zero, write at posedge.
  always @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rf_rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_waddr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'hAAAA_0001);
    set_req(1, 5'd2, 32'hBBBB_0002);
    set_req(2, 5'd3, 32'hCCCC_0003);
    step();
    step();
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    checks++;
    if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    checks++;
    if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    checks++;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++;
    rst = 1'b0;
    #1;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL post_reset_ready got=%b exp=001", req_ready); end
    checks++;
    step();
    if (rf_we !== 1'b1 || rf_waddr !== 5'd1) begin
      errors++; $display("FAIL first_accept got we=%b addr=%0d exp we=1 addr=1", rf_we, rf_waddr);
    end
    checks++;
    // Reset mid-transfer: the output stage holds r1's write, ptr=1.
    #1;
    rst = 1'b1;
    #1;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++; $display("FAIL midreset_stage got we=%b addr=%0d data=%h exp 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL midreset_ready got=%b exp=000", req_ready); end
    checks++;
    step();
    rst = 1'b0;
    #1;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL rerelease_ready got=%b exp=001", req_ready); end
    checks++;
    if (regs[1] !== 32'd0) begin errors++; $display("FAIL discarded_write got r1=%h exp=0", regs[1]); end
    checks++;
    req_valid = 3'b000;
    step();
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] dtab [3];
    logic [2:0] exp_rdy;
    int e;
    dtab[0] = 32'hAAAA_0001;
    dtab[1] = 32'hBBBB_0002;
    dtab[2] = 32'hCCCC_0003;
    e = 0;
    req_valid = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 3'b001 << e;
      if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy); end
      checks++;
      step();
      if (rf_we !== 1'b1 || rf_waddr !== 5'(e + 1) || rf_wdata !== dtab[e]) begin
        errors++; $display("FAIL rr_stage[%0d] got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                           k, rf_we, rf_waddr, rf_wdata, e + 1, dtab[e]);
      end
      checks++;
      e = (e + 1) % 3;
    end
    req_valid = 3'b000;
    step();
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rr_idle_we got=%b exp=0", rf_we); end
    checks++;
    if (rf_waddr !== 5'd3 || rf_wdata !== 32'hCCCC_0003) begin
      errors++; $display("FAIL rr_idle_hold got addr=%0d data=%h exp addr=3 data=cccc0003", rf_waddr, rf_wdata);
    end
    checks++;
    step();
    if (regs[1] !== 32'hAAAA_0001 || regs[2] !== 32'hBBBB_0002 || regs[3] !== 32'hCCCC_0003) begin
      errors++; $display("FAIL rr_regfile got r1=%h r2=%h r3=%h exp aaaa0001 bbbb0002 cccc0003",
                         regs[1], regs[2], regs[3]);
    end
    checks++;
  endtask

  // ptr=0 on entry; leaves ptr=2.
  task automatic test_r0_write();
    set_req(1, 5'd0, 32'hDEAD_BEEF);
    raddr1 = 5'd0;
    req_valid = 3'b010;
    #1;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL r0_ready got=%b exp=010", req_ready); end
    checks++;
    step();
    req_valid = 3'b000;
    #1;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got=%b exp=0", rf_we); end
    checks++;
    step();
    if (rdata1 !== 32'd0 || regs[0] !== 32'd0) begin
      errors++; $display("FAIL r0_read got rdata1=%h r0=%h exp 0", rdata1, regs[0]);
    end
    checks++;
  endtask

  // ptr=2 on entry, only requester 0 valid; leaves ptr=1.
  task automatic test_forwarding();
    set_req(0, 5'd5, 32'h1234_5678);
    raddr1 = 5'd5;
    raddr2 = 5'd5;
    req_valid = 3'b001;
    #1;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL fwd_ready got=%b exp=001", req_ready); end
    checks++;
    if (rdata1 !== 32'd0) begin errors++; $display("FAIL fwd_before got=%h exp=0", rdata1); end
    checks++;
    step();
    req_valid = 3'b000;
    #1;
    if (regs[5] !== 32'd0) begin errors++; $display("FAIL fwd_rf_early got r5=%h exp=0", regs[5]); end
    checks++;
    if (rdata1 !== 32'h1234_5678 || rdata2 !== 32'h1234_5678) begin
      errors++; $display("FAIL fwd_inflight got rdata1=%h rdata2=%h exp 12345678", rdata1, rdata2);
    end
    checks++;
    step();
    if (rf_we !== 1'b0 || rdata1 !== 32'h1234_5678 || rdata2 !== 32'h1234_5678) begin
      errors++; $display("FAIL fwd_after got we=%b rdata1=%h rdata2=%h exp we=0 12345678", rf_we, rdata1, rdata2);
    end
    checks++;
  endtask

  // ptr=1 on entry.
  task automatic test_hold_conflict();
    set_req(1, 5'd9, 32'h0000_0009);
    req_valid = 3'b010;
    step();
    set_req(0, 5'd7, 32'h0000_0011);
    set_req(2, 5'd7, 32'h0000_0022);
    req_valid = 3'b101;
    #1;
    if (req_ready !== 3'b100) begin errors++; $display("FAIL conflict_first got=%b exp=100", req_ready); end
    checks++;
    step();
    req_valid = 3'b001;
    wb_hold = 1'b1;
    #1;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL hold_ready got=%b exp=000", req_ready); end
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h22) begin
      errors++; $display("FAIL hold_stage got we=%b addr=%0d data=%h exp we=1 addr=7 data=22", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    step();
    if (rf_we !== 1'b0 || req_ready !== 3'b000) begin
      errors++; $display("FAIL hold_idle got we=%b ready=%b exp we=0 ready=000", rf_we, req_ready);
    end
    checks++;
    if (regs[7] !== 32'h22) begin errors++; $display("FAIL hold_first_write got r7=%h exp=22", regs[7]); end
    checks++;
    step();
    wb_hold = 1'b0;
    #1;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL unhold_ready got=%b exp=001", req_ready); end
    checks++;
    step();
    req_valid = 3'b000;
    if (rf_we !== 1'b1 || rf_wdata !== 32'h11) begin
      errors++; $display("FAIL conflict_second got we=%b data=%h exp we=1 data=11", rf_we, rf_wdata);
    end
    checks++;
    step();
    step();
    if (regs[7] !== 32'h11) begin errors++; $display("FAIL conflict_final got r7=%h exp=11", regs[7]); end
    checks++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst = 1'b1;
    req_valid = '0;
    req_waddr = '0;
    req_wdata = '0;
    wb_hold = 1'b0;
    raddr1 = '0;
    raddr2 = '0;
    test_reset();
    test_round_robin();
    test_r0_write();
    test_forwarding();
    test_hold_conflict();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. It shares the port round-robin between NREQ write-back sources (ALU, load unit, multi-cycle mul/div) using a valid/ready handshake, and registers the winning write into a one-entry output stage that drives the register file. Read-after-write forwarding covers that in-flight write, so the register file's two combinational read ports never return stale data.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- DW, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant; transfer occurs when valid & ready at posedge
- req_waddr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed data; requester i at [i*DW +: DW]
- wb_hold  in  1  freezes arbitration; no grants while high
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- raddr1, raddr2  in  AW  read addresses also presented to the register file
- rf_rdata1, rf_rdata2  in  DW  raw register-file read data
- rdata1, rdata2  out  DW  forwarded read data for the datapath

## Operation
- Round-robin pointer ptr (0..NREQ-1).
- Grant goes to the first asserted req_valid at index ptr, ptr+1, ... modulo NREQ.
- req_ready is one-hot (or zero) and combinational from req_valid, ptr and wb_hold.
- req_ready is zero when wb_hold=1 or when no requester is valid.
- On accept of requester g:
  - ptr <= (g+1) mod NREQ.
  - rf_waddr <= req_waddr[g], rf_wdata <= req_wdata[g].
  - rf_we <= (req_waddr[g] != 0).
- Writes to r0 are still accepted (req_ready=1) but are dropped: rf_we stays 0.
- No accept in a cycle: rf_we <= 0; rf_waddr and rf_wdata hold their values; ptr holds.
- Requester side: a valid request keeps its addr/data stable until accepted. The arbiter does not check this.
- Two requesters targeting the same register are serialised in grant order. The later grant wins in the register file.
- Forwarding, for each read port k:
  - If rf_we && rf_waddr==raddrk && raddrk!=0, then rdatak = rf_wdata.
  - Otherwise rdatak = rf_rdatak.
  - Combinational.
- Reset (any time, including mid-transfer):
  - rf_we=0, rf_waddr=0, rf_wdata=0, ptr=0.
  - req_ready is zero while rst is high.
  - An in-flight write is discarded.

## Timing
- Accept at posedge N: rf_we/rf_waddr/rf_wdata are valid during cycle N to N+1, and the register file captures the write at posedge N+1.
- Visibility: rdata shows the new value from just after posedge N via forwarding, then from the register file itself after N+1.
- Throughput is one write per cycle. Back-to-back accepts keep rf_we continuously high.
- wb_hold rising in cycle N: no accept at posedge N; rf_we low after posedge N. The write already in the output stage still completes.
- Fairness: a continuously valid requester waits at most NREQ-1 accepts before it is granted.
- No combinational path from rf_rdata to req_ready.

## Structure
- A shared package (mips_pkg) holds:
  - Register-address width (AW=5).
  - Data width (DW=32).
  - Constant REG_ZERO = 5'd0.
  - Requester index constants: WB_ALU=0, WB_LOAD=1, WB_MULDIV=2.
- One sub-module, rr_arbiter (parameter N), is natural. It takes req[N], ptr and enable, and produces a one-hot grant[N] plus a grant index. The pointer register, output stage and forwarding mux stay in regfile_wb_arbiter.
- The register file is instantiated beside this block, not inside it.

## Test plan
- **Reset:** assert rst mid-transfer with req_valid=3'b111 -> rf_we=0, rf_waddr=0, rf_wdata=0, req_ready=0; after release the first grant goes to requester 0.
- **Round-robin:** hold req_valid=3'b111, waddr 1/2/3, data A/B/C -> grants 0,1,2,0,... in consecutive cycles; rf_we continuously high; register file r1=A, r2=B, r3=C.
- **r0 write:** requester 1 writes waddr=0, data 0xDEADBEEF -> req_ready[1]=1; rf_we stays 0; r0 reads 0; rdata1 with raddr1=0 is 0.
- **Forwarding:** requester 0 writes r5=0x12345678, with raddr1=raddr2=5 held -> rdata1=rdata2=0x12345678 from the cycle after the accept edge, and remains so after the register-file write.
- **Hold and conflict:** requesters 0 and 2 both target r7 (0x11, 0x22) with ptr=2 -> requester 2 is granted first, then requester 0; final r7=0x11. Raising wb_hold between the two grants -> no grant while held; requester 0 is granted the cycle after wb_hold falls.
